mem_wb_pipe: RTL and testbench

MEM_WB_PIPE -- requirements
Module: mem_wb_pipe

---
 rtl/mem_wb_pipe_pkg.sv | 20 ++
 rtl/mem_wb_pipe_data_ram.sv | 24 ++
 rtl/mem_wb_pipe.sv | 89 ++++++++
 tb/tb_mem_wb_pipe.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_wb_pipe_pkg.sv
// Shared processor defines: datapath widths, the r0 constant and the
// control-bit bundle carried through the EX/MEM register.
package mem_wb_pipe_pkg;

    localparam int         DATA_W   = 32;
    localparam int         DMEM_AW  = 8;
    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic regWrite;
        logic memWrite;
        logic memToReg;
    } ctrlT;

    // Loads and stores must be word aligned; anything else is an address error
    function automatic logic isMisaligned(input ctrlT ctrl, input logic [1:0] byteOffset);
        return (ctrl.memWrite | ctrl.memToReg) & (byteOffset != 2'b00);
    endfunction

endpackage

// File: rtl/mem_wb_pipe_data_ram.sv
// Word-addressed data memory: one synchronous write port, one asynchronous
// read port, deliberately without reset.
module data_ram #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              writeEnable,
    input  logic [ADDR_W-1:0] wordAddr,
    input  logic [DATA_W-1:0] writeData,
    output logic [DATA_W-1:0] readData
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (writeEnable) begin
            mem[wordAddr] <= writeData;
        end
    end

    assign readData = mem[wordAddr];

endmodule

// File: rtl/mem_wb_pipe.sv
// MEM and WB stages of the pipeline: EX/MEM and MEM/WB registers, the data
// memory access and the sticky misaligned-access flag.
module mem_wb_pipe
    import mem_wb_pipe_pkg::*;
#(
    parameter int DATA_W  = mem_wb_pipe_pkg::DATA_W,
    parameter int DMEM_AW = mem_wb_pipe_pkg::DMEM_AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] ALUResult_ex,
    input  logic [DATA_W-1:0] MemWriteData_ex,
    input  logic [4:0]        RegWriteAddr_ex,
    input  logic              RegWrite_ex,
    input  logic              MemWrite_ex,
    input  logic              MemtoReg_ex,
    input  logic              Flush_ex,
    output logic [DATA_W-1:0] ALUResult_mem,
    output logic [4:0]        RegWriteAddr_mem,
    output logic              RegWrite_mem,
    output logic [DATA_W-1:0] RegWriteData_wb,
    output logic [4:0]        RegWriteAddr_wb,
    output logic              RegWrite_wb,
    output logic              AddrErr
);

    ctrlT              ctrlMem;
    logic [DATA_W-1:0] writeDataMem;
    logic [DATA_W-1:0] readData;
    logic              misaligned;
    logic              memWriteEnable;
    logic [DATA_W-1:0] wbData;

    // A flushed EX instruction enters MEM as a bubble with every control bit clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ctrlMem          <= '0;
            ALUResult_mem    <= '0;
            RegWriteAddr_mem <= REG_ZERO;
            writeDataMem     <= '0;
        end else if (Flush_ex) begin
            ctrlMem          <= '0;
            ALUResult_mem    <= '0;
            RegWriteAddr_mem <= REG_ZERO;
            writeDataMem     <= '0;
        end else begin
            ctrlMem.regWrite <= RegWrite_ex;
            ctrlMem.memWrite <= MemWrite_ex;
            ctrlMem.memToReg <= MemtoReg_ex;
            ALUResult_mem    <= ALUResult_ex;
            RegWriteAddr_mem <= RegWriteAddr_ex;
            writeDataMem     <= MemWriteData_ex;
        end
    end

    assign RegWrite_mem = ctrlMem.regWrite;
    assign misaligned   = isMisaligned(ctrlMem, ALUResult_mem[1:0]);

    // Reset is folded into the write enable so a store caught by reset never lands
    assign memWriteEnable = rst_n & ctrlMem.memWrite & ~misaligned;

    data_ram #(
        .DATA_W(DATA_W),
        .ADDR_W(DMEM_AW)
    ) dataRam (
        .clk        (clk),
        .writeEnable(memWriteEnable),
        .wordAddr   (ALUResult_mem[DMEM_AW+1:2]),
        .writeData  (writeDataMem),
        .readData   (readData)
    );

    assign wbData = ctrlMem.memToReg ? readData : ALUResult_mem;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            RegWriteData_wb <= '0;
            RegWriteAddr_wb <= REG_ZERO;
            RegWrite_wb     <= 1'b0;
            AddrErr         <= 1'b0;
        end else begin
            RegWriteData_wb <= wbData;
            RegWriteAddr_wb <= RegWriteAddr_mem;
            RegWrite_wb     <= ctrlMem.regWrite & ~(ctrlMem.memToReg & misaligned);
            AddrErr         <= AddrErr | misaligned;
        end
    end

endmodule

// File: tb/tb_mem_wb_pipe.sv
// Scoreboard bench for mem_wb_pipe: stimulus pushes expected write-backs,
// a monitor pops and compares them whenever the WB stage writes.
module tb_mem_wb_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] ALUResult_ex;
    logic [31:0] MemWriteData_ex;
    logic [4:0]  RegWriteAddr_ex;
    logic        RegWrite_ex;
    logic        MemWrite_ex;
    logic        MemtoReg_ex;
    logic        Flush_ex;
    logic [31:0] ALUResult_mem;
    logic [4:0]  RegWriteAddr_mem;
    logic        RegWrite_mem;
    logic [31:0] RegWriteData_wb;
    logic [4:0]  RegWriteAddr_wb;
    logic        RegWrite_wb;
    logic        AddrErr;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  addr;
        int          cycle;
    } expT;

    expT expQ[$];
    int  checks = 0;
    int  errors = 0;
    int  cycle  = 0;

    mem_wb_pipe dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ALUResult_ex    (ALUResult_ex),
        .MemWriteData_ex (MemWriteData_ex),
        .RegWriteAddr_ex (RegWriteAddr_ex),
        .RegWrite_ex     (RegWrite_ex),
        .MemWrite_ex     (MemWrite_ex),
        .MemtoReg_ex     (MemtoReg_ex),
        .Flush_ex        (Flush_ex),
        .ALUResult_mem   (ALUResult_mem),
        .RegWriteAddr_mem(RegWriteAddr_mem),
        .RegWrite_mem    (RegWrite_mem),
        .RegWriteData_wb (RegWriteData_wb),
        .RegWriteAddr_wb (RegWriteAddr_wb),
        .RegWrite_wb     (RegWrite_wb),
        .AddrErr         (AddrErr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cycle);
        end
    endtask

    // Drive one EX instruction at the falling edge, then check what MEM captured
    task automatic applyStimulus(input logic [31:0] alu, input logic [31:0] wdata,
                                 input logic [4:0] rd, input logic rw, input logic mw,
                                 input logic m2r, input logic fl,
                                 input logic expWb, input logic [31:0] expData);
        expT e;
        @(negedge clk);
        ALUResult_ex    = alu;
        MemWriteData_ex = wdata;
        RegWriteAddr_ex = rd;
        RegWrite_ex     = rw;
        MemWrite_ex     = mw;
        MemtoReg_ex     = m2r;
        Flush_ex        = fl;
        if (expWb) begin
            e.data  = expData;
            e.addr  = rd;
            e.cycle = cycle + 2;
            expQ.push_back(e);
        end
        @(posedge clk);
        #1;
        checkOutput("memRegWrite", {31'b0, RegWrite_mem}, {31'b0, fl ? 1'b0 : rw});
        checkOutput("memAluResult", ALUResult_mem, fl ? 32'h0 : alu);
        if (!fl) checkOutput("memRegAddr", {27'b0, RegWriteAddr_mem}, {27'b0, rd});
    endtask

    task automatic nop();
        applyStimulus(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        applyStimulus(addr, data, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic load(input logic [31:0] addr, input logic [4:0] rd, input logic [31:0] expData);
        applyStimulus(addr, 32'h0, rd, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, expData);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "AluMem"}, ALUResult_mem, 32'h0);
        checkOutput({tag, "AddrMem"}, {27'b0, RegWriteAddr_mem}, 32'h0);
        checkOutput({tag, "RegWriteMem"}, {31'b0, RegWrite_mem}, 32'h0);
        checkOutput({tag, "DataWb"}, RegWriteData_wb, 32'h0);
        checkOutput({tag, "AddrWb"}, {27'b0, RegWriteAddr_wb}, 32'h0);
        checkOutput({tag, "RegWriteWb"}, {31'b0, RegWrite_wb}, 32'h0);
        checkOutput({tag, "AddrErr"}, {31'b0, AddrErr}, 32'h0);
    endtask

    // Monitor: every write-back must match the oldest expectation, on time
    initial begin
        expT e;
        forever begin
            @(posedge clk);
            #1;
            if (RegWrite_wb) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL wbUnexpected: got data %h addr %0d, required no write-back",
                             RegWriteData_wb, RegWriteAddr_wb);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("wbData", RegWriteData_wb, e.data);
                    checkOutput("wbAddr", {27'b0, RegWriteAddr_wb}, {27'b0, e.addr});
                    checkOutput("wbCycle", 32'(cycle), 32'(e.cycle));
                end
            end else if (expQ.size() != 0 && expQ[0].cycle < cycle) begin
                e = expQ.pop_front();
                checks++;
                errors++;
                $display("[TB] FAIL wbMissing: got no write-back by cycle %0d, required data %h addr %0d",
                         cycle, e.data, e.addr);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no end of test, required finish before 200000");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n           = 1'b0;
        ALUResult_ex    = '0;
        MemWriteData_ex = '0;
        RegWriteAddr_ex = '0;
        RegWrite_ex     = 1'b0;
        MemWrite_ex     = 1'b0;
        MemtoReg_ex     = 1'b0;
        Flush_ex        = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Plain ALU result flowing through both registers
        applyStimulus(32'h5, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h5);
        // r0 destinations are passed through untouched
        applyStimulus(32'h77, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h77);

        // Store immediately followed by a load of the same word
        store(32'h10, 32'hDEADBEEF);
        load(32'h10, 5'd5, 32'hDEADBEEF);

        // Flushed store must not reach memory or the register file
        store(32'h20, 32'hAAAA5555);
        applyStimulus(32'h20, 32'h11111111, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        load(32'h20, 5'd8, 32'hAAAA5555);

        // Store in MEM completes while the instruction behind it is flushed
        store(32'h24, 32'h0BADF00D);
        applyStimulus(32'h24, 32'h22222222, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        load(32'h24, 5'd9, 32'h0BADF00D);

        // Byte address 0x400 wraps onto word 0
        store(32'h400, 32'h00001234);
        load(32'h000, 5'd11, 32'h00001234);
        nop();
        checkOutput("addrErrClear", {31'b0, AddrErr}, 32'h0);

        // Misaligned store is dropped and raises the sticky flag one edge later
        store(32'h13, 32'h55555555);
        checkOutput("addrErrNotYet", {31'b0, AddrErr}, 32'h0);
        nop();
        checkOutput("addrErrSet", {31'b0, AddrErr}, 32'h1);
        load(32'h10, 5'd4, 32'hDEADBEEF);
        // Misaligned load must not write back
        applyStimulus(32'h12, 32'h0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 1; i <= 10; i++) begin
            applyStimulus(32'(i * 3), 32'h0, 5'(i), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'(i * 3));
            checkOutput("addrErrSticky", {31'b0, AddrErr}, 32'h1);
        end
        nop();
        nop();

        // Reset arriving while a store sits in MEM
        store(32'h40, 32'h13579BDF);
        nop();
        nop();
        store(32'h40, 32'h99999999);
        @(negedge clk);
        rst_n        = 1'b0;
        MemWrite_ex  = 1'b0;
        ALUResult_ex = '0;
        @(posedge clk);
        #1;
        checkAllZero("midReset");
        @(negedge clk);
        rst_n = 1'b1;
        load(32'h40, 5'd10, 32'h13579BDF);

        nop();
        nop();
        nop();
        checkOutput("queueEmpty", 32'(expQ.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
